// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: LdStCtrl encodings
// (also used by the control unit), FSM state type and grant identifiers.
package mips_mem_pkg;

  localparam logic [2:0] LDST_LB  = 3'b000;
  localparam logic [2:0] LDST_LH  = 3'b001;
  localparam logic [2:0] LDST_LW  = 3'b010;
  localparam logic [2:0] LDST_LBU = 3'b011;
  localparam logic [2:0] LDST_LHU = 3'b100;
  localparam logic [2:0] LDST_SB  = 3'b101;
  localparam logic [2:0] LDST_SH  = 3'b110;
  localparam logic [2:0] LDST_SW  = 3'b111;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// slave: the arbiter's view; master: the surrounding pipeline + memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic [2:0]  ls_ctrl;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_ctrl, ls_addr, ls_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, if_err, ls_ack, ls_rdata, ls_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_ctrl, ls_addr, ls_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, if_err, ls_ack, ls_rdata, ls_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_ldst_align.sv
// Combinational lane logic for one load/store: byte enables, lane-replicated
// store data, extended load data and the alignment check.
module ldst_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        is_store
);

  logic [15:0] lane;

  // decode ctrl into lane enables, replicated store data and extended load data
  always_comb begin
    be         = 4'hF;
    wdata_rep  = wdata;
    rdata_ext  = '0;
    misaligned = 1'b0;
    is_store   = 1'b0;
    lane       = 16'(rdata >> {addr_lo, 3'b000});
    case (ctrl)
      LDST_LB:  rdata_ext = {{24{lane[7]}}, lane[7:0]};
      LDST_LBU: rdata_ext = {24'h0, lane[7:0]};
      LDST_LH: begin
        misaligned = addr_lo[0];
        rdata_ext  = {{16{lane[15]}}, lane[15:0]};
      end
      LDST_LHU: begin
        misaligned = addr_lo[0];
        rdata_ext  = {16'h0, lane[15:0]};
      end
      LDST_LW: begin
        misaligned = (addr_lo != 2'b00);
        rdata_ext  = rdata;
      end
      LDST_SB: begin
        is_store  = 1'b1;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      LDST_SH: begin
        is_store   = 1'b1;
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
      end
      LDST_SW: begin
        is_store   = 1'b1;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-ported unified memory between
// instruction fetch and the load/store unit; one access in flight at a time.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        last_gnt;
  logic        gnt_ls;
  logic [7:0]  cnt;
  logic [2:0]  ls_ctrl_q;
  logic [1:0]  ls_lo_q;

  logic        grant, grant_ls, grant_mis, timeout_hit;

  logic [2:0]  al_ctrl;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_mis, al_store;

  // Live LS fields decide grant/alignment in IDLE; the latched copy drives
  // load extension afterwards so the requester is free to change them.
  assign al_ctrl = (state == ST_IDLE) ? bus.ls_ctrl       : ls_ctrl_q;
  assign al_lo   = (state == ST_IDLE) ? bus.ls_addr[1:0]  : ls_lo_q;

  ldst_align u_align (
    .ctrl       (al_ctrl),
    .addr_lo    (al_lo),
    .wdata      (bus.ls_wdata),
    .rdata      (bus.mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis),
    .is_store   (al_store)
  );

  assign timeout_hit = (cnt == TO_LAST);
  assign bus.busy    = (state != ST_IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // grant selection and next state
  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_ls  = 1'b0;
    grant_mis = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          grant     = 1'b1;
          grant_ls  = bus.ls_req && (!bus.if_req || last_gnt == GNT_IF);
          grant_mis = grant_ls ? al_mis : (bus.if_addr[1:0] != 2'b00);
          state_nx  = grant_mis ? ST_RESP : ST_MEM;
        end
      end
      ST_MEM:  if (bus.mem_ack || timeout_hit) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Acks are set on the edge into RESP, so they are high exactly for the RESP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt      <= GNT_IF;
      gnt_ls        <= 1'b0;
      cnt           <= '0;
      ls_ctrl_q     <= '0;
      ls_lo_q       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_err    <= 1'b0;
      bus.ls_ack    <= 1'b0;
      bus.ls_rdata  <= '0;
      bus.ls_err    <= 1'b0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.ls_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            last_gnt  <= grant_ls;
            gnt_ls    <= grant_ls;
            cnt       <= '0;
            ls_ctrl_q <= bus.ls_ctrl;
            ls_lo_q   <= bus.ls_addr[1:0];
            if (grant_mis) begin
              if (grant_ls) begin
                bus.ls_ack   <= 1'b1;
                bus.ls_err   <= 1'b1;
                bus.ls_rdata <= '0;
              end else begin
                bus.if_ack   <= 1'b1;
                bus.if_err   <= 1'b1;
                bus.if_rdata <= '0;
              end
            end else begin
              bus.mem_req <= 1'b1;
              if (grant_ls) begin
                bus.mem_we    <= al_store;
                bus.mem_be    <= al_be;
                bus.mem_addr  <= {bus.ls_addr[31:2], 2'b00};
                bus.mem_wdata <= al_wdata;
              end else begin
                bus.mem_we    <= 1'b0;
                bus.mem_be    <= 4'hF;
                bus.mem_addr  <= {bus.if_addr[31:2], 2'b00};
                bus.mem_wdata <= '0;
              end
            end
          end
        end
        ST_MEM: begin
          if (bus.mem_ack || timeout_hit) begin
            bus.mem_req <= 1'b0;
            if (gnt_ls) begin
              bus.ls_ack   <= 1'b1;
              bus.ls_err   <= !bus.mem_ack;
              bus.ls_rdata <= bus.mem_ack ? al_rdata : '0;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_err   <= !bus.mem_ack;
              bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester tasks push expected acks,
// a memory model checks issued accesses, a monitor compares every ack.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wd;
    int          delay;
    bit          noack;
    logic [31:0] rdata;
  } mem_t;

  resp_t ifq[$];
  resp_t lsq[$];
  mem_t  mq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit chk_wd, input int delay,
                         input bit noack, input logic [31:0] rdata);
    mem_t m;
    m.we = we; m.be = be; m.addr = addr; m.wdata = wdata; m.chk_wd = chk_wd;
    m.delay = delay; m.noack = noack; m.rdata = rdata;
    mq.push_back(m);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"},   {31'b0, bus.mem_req}, 32'd0);
    check({tag, "_mem_we"},    {31'b0, bus.mem_we},  32'd0);
    check({tag, "_mem_be"},    {28'b0, bus.mem_be},  32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr,         32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,        32'd0);
    check({tag, "_if_ack"},    {31'b0, bus.if_ack},  32'd0);
    check({tag, "_if_err"},    {31'b0, bus.if_err},  32'd0);
    check({tag, "_if_rdata"},  bus.if_rdata,         32'd0);
    check({tag, "_ls_ack"},    {31'b0, bus.ls_ack},  32'd0);
    check({tag, "_ls_err"},    {31'b0, bus.ls_err},  32'd0);
    check({tag, "_ls_rdata"},  bus.ls_rdata,         32'd0);
    check({tag, "_busy"},      {31'b0, bus.busy},    32'd0);
  endtask

  // Issue one request, expect its ack 'lat' cycles after the IDLE sample,
  // then drop req on the edge after the ack.
  task automatic do_req(input bit is_ls, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input bit exp_err, input int lat);
    resp_t r;
    bit    got;
    got = 1'b0;
    @(posedge clk); #1;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    r.cyc   = cyc + lat;
    if (is_ls) begin
      bus.ls_ctrl  = ctrl;
      bus.ls_addr  = addr;
      bus.ls_wdata = wdata;
      bus.ls_req   = 1'b1;
      lsq.push_back(r);
    end else begin
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
      ifq.push_back(r);
    end
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge clk);
      got = is_ls ? bus.ls_ack : bus.if_ack;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_ack_wait: no ack within 600 cycles, required one", is_ls ? "ls" : "if");
    end
    @(posedge clk); #1;
    if (is_ls) bus.ls_req = 1'b0;
    else       bus.if_req = 1'b0;
  endtask

  // ack scoreboard monitor
  resp_t mon_r;
  always @(negedge clk) begin
    if (bus.if_ack) begin
      if (ifq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL if_unexpected_ack: got ack at cycle %0d, required none", cyc);
      end else begin
        mon_r = ifq.pop_front();
        check("if_rdata",     bus.if_rdata,         mon_r.rdata);
        check("if_err",       {31'b0, bus.if_err},  {31'b0, mon_r.err});
        check("if_ack_cycle", cyc,                  mon_r.cyc);
      end
    end
    if (bus.ls_ack) begin
      if (lsq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ls_unexpected_ack: got ack at cycle %0d, required none", cyc);
      end else begin
        mon_r = lsq.pop_front();
        check("ls_rdata",     bus.ls_rdata,         mon_r.rdata);
        check("ls_err",       {31'b0, bus.ls_err},  {31'b0, mon_r.err});
        check("ls_ack_cycle", cyc,                  mon_r.cyc);
      end
    end
  end

  // memory model: checks each issued access and answers after its delay
  mem_t mm;
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (mq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_unexpected_req: got access to 0x%08h, required none", bus.mem_addr);
          for (int n = 0; n < 400 && bus.mem_req; n++) @(negedge clk);
        end else begin
          mm = mq.pop_front();
          check("mem_we",   {31'b0, bus.mem_we}, {31'b0, mm.we});
          check("mem_be",   {28'b0, bus.mem_be}, {28'b0, mm.be});
          check("mem_addr", bus.mem_addr,        mm.addr);
          if (mm.chk_wd) check("mem_wdata", bus.mem_wdata, mm.wdata);
          if (mm.noack) begin
            for (int n = 0; n < 400 && bus.mem_req; n++) @(negedge clk);
          end else begin
            repeat (mm.delay) @(negedge clk);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mm.rdata;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  bit got_req;
  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_ctrl = '0; bus.ls_addr = '0; bus.ls_wdata = '0;

    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // contention from reset: LS first (last_gnt=IF), then IF
    exp_mem(1'b0, 4'hF, 32'h0000_0040, '0, 1'b0, 0, 1'b0, 32'h1111_2222);
    exp_mem(1'b0, 4'hF, 32'h0000_0080, '0, 1'b0, 0, 1'b0, 32'h3333_4444);
    fork
      do_req(1'b1, LDST_LW, 32'h0000_0040, '0, 32'h1111_2222, 1'b0, 2);
      do_req(1'b0, 3'b000,  32'h0000_0080, '0, 32'h3333_4444, 1'b0, 5);
    join

    // single fetch at 0x100, memory acks one cycle after mem_req
    exp_mem(1'b0, 4'hF, 32'h0000_0100, '0, 1'b0, 0, 1'b0, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b000, 32'h0000_0100, '0, 32'hDEAD_BEEF, 1'b0, 2);

    // LB 0x203: lane 3 = 0x80, sign-extended
    exp_mem(1'b0, 4'hF, 32'h0000_0200, '0, 1'b0, 0, 1'b0, 32'h80FF_FF00);
    do_req(1'b1, LDST_LB, 32'h0000_0203, '0, 32'hFFFF_FF80, 1'b0, 2);

    // contention after an LS grant: IF first, then LS (LBU 0x201 -> 0xF1)
    exp_mem(1'b0, 4'hF, 32'h0000_0104, '0, 1'b0, 0, 1'b0, 32'h5555_6666);
    exp_mem(1'b0, 4'hF, 32'h0000_0200, '0, 1'b0, 0, 1'b0, 32'h0000_F100);
    fork
      do_req(1'b0, 3'b000,   32'h0000_0104, '0, 32'h5555_6666, 1'b0, 2);
      do_req(1'b1, LDST_LBU, 32'h0000_0201, '0, 32'h0000_00F1, 1'b0, 5);
    join

    // LHU 0x202 upper half, zero-extended; LH 0x200 lower half, sign-extended
    exp_mem(1'b0, 4'hF, 32'h0000_0200, '0, 1'b0, 0, 1'b0, 32'h80FF_FF00);
    do_req(1'b1, LDST_LHU, 32'h0000_0202, '0, 32'h0000_80FF, 1'b0, 2);
    exp_mem(1'b0, 4'hF, 32'h0000_0200, '0, 1'b0, 0, 1'b0, 32'h1234_8001);
    do_req(1'b1, LDST_LH, 32'h0000_0200, '0, 32'hFFFF_8001, 1'b0, 2);

    // stores: lane enables and replicated data; rdata 0
    exp_mem(1'b1, 4'b0010, 32'h0000_0200, 32'hABAB_ABAB, 1'b1, 0, 1'b0, 32'hFFFF_FFFF);
    do_req(1'b1, LDST_SB, 32'h0000_0201, 32'h0000_00AB, 32'h0, 1'b0, 2);
    exp_mem(1'b1, 4'b1100, 32'h0000_0200, 32'h1234_1234, 1'b1, 0, 1'b0, 32'hFFFF_FFFF);
    do_req(1'b1, LDST_SH, 32'h0000_0202, 32'h0000_1234, 32'h0, 1'b0, 2);
    exp_mem(1'b1, 4'hF, 32'h0000_0204, 32'hCAFE_F00D, 1'b1, 2, 1'b0, 32'hFFFF_FFFF);
    do_req(1'b1, LDST_SW, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 1'b0, 4);

    // reset while in MEM: everything clears at once, no ack afterwards
    exp_mem(1'b0, 4'hF, 32'h0000_0400, '0, 1'b0, 0, 1'b1, '0);
    @(posedge clk); #1;
    bus.ls_ctrl = LDST_LW;
    bus.ls_addr = 32'h0000_0400;
    bus.ls_req  = 1'b1;
    got_req = 1'b0;
    for (int n = 0; n < 10 && !got_req; n++) begin
      @(negedge clk);
      got_req = bus.mem_req;
    end
    check("midreset_mem_req_before", {31'b0, bus.mem_req}, 32'd1);
    check("midreset_busy_before",    {31'b0, bus.busy},    32'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    bus.ls_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // misaligned accesses: no memory access, ack+err one cycle after sample
    do_req(1'b1, LDST_SH, 32'h0000_0203, 32'h0000_1234, 32'h0, 1'b1, 1);
    do_req(1'b0, 3'b000,  32'h0000_0102, '0,            32'h0, 1'b1, 1);
    do_req(1'b1, LDST_LW, 32'h0000_0206, '0,            32'h0, 1'b1, 1);

    // no mem_ack: abort after 255 MEM cycles
    exp_mem(1'b0, 4'hF, 32'h0000_0300, '0, 1'b0, 0, 1'b1, '0);
    do_req(1'b1, LDST_LW, 32'h0000_0300, '0, 32'h0, 1'b1, 256);

    repeat (5) @(negedge clk);
    check("idle_busy_end",   {31'b0, bus.busy}, 32'd0);
    check("ifq_drained",     ifq.size(), 32'd0);
    check("lsq_drained",     lsq.size(), 32'd0);
    check("memq_drained",    mq.size(),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
